// File: rtl/c7bifu_pkg.sv
// Shared definitions for the IFU fetch control slice: pf address select
// indices and the in-flight depth bound.
package c7bifu_pkg;

   localparam int MAX_OUTSTANDING = 8;

   localparam int NUM_SEL  = 6;
   localparam int SEL_INIT = 0;
   localparam int SEL_OLD  = 1;
   localparam int SEL_INC  = 2;
   localparam int SEL_BRN  = 3;
   localparam int SEL_ISR  = 4;
   localparam int SEL_ERT  = 5;

   typedef logic [NUM_SEL-1:0] pf_sel_t;

   // Keeps the in-flight depth inside 1..MAX_OUTSTANDING whatever the caller passes.
   function automatic int clamp_depth(input int n);
      if (n < 1)
         return 1;
      else if (n > MAX_OUTSTANDING)
         return MAX_OUTSTANDING;
      else
         return n;
   endfunction

endpackage

// File: rtl/c7bifu_fcl_mo_if.sv
// IFU <-> ICU fetch request/return channel.
interface c7bifu_fcl_mo_if;

   logic ifu_icu_req_ic1;
   logic icu_ifu_ack_ic1;
   logic icu_ifu_data_valid_ic2;

   modport master (
      output ifu_icu_req_ic1,
      input  icu_ifu_ack_ic1,
      input  icu_ifu_data_valid_ic2
   );

   modport slave (
      input  ifu_icu_req_ic1,
      output icu_ifu_ack_ic1,
      output icu_ifu_data_valid_ic2
   );

endinterface

// File: rtl/c7bifu_fcl_inflight.sv
// Circular buffer of kill bits, one per acked fetch whose data has not yet
// returned. Flush marks every entry stale; data is popped in ack order.
module c7bifu_fcl_inflight
   import c7bifu_pkg::*;
#(
   parameter int OUTSTANDING = 2,
   parameter int CNT_W       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             push_kill,
   input  logic             pop,
   input  logic             flush,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] count_nxt,
   output logic             empty,
   output logic             full,
   output logic             head_kill
);

   localparam int DEPTH = clamp_depth(OUTSTANDING);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   logic [PTR_W-1:0] head_q, tail_q, head_inc, tail_inc;
   logic [DEPTH-1:0] kill_q, kill_nxt;
   logic [CNT_W-1:0] count_q;

   assign head_inc  = (head_q == PTR_LAST) ? '0 : head_q + PTR_W'(1);
   assign tail_inc  = (tail_q == PTR_LAST) ? '0 : tail_q + PTR_W'(1);
   assign count_nxt = count_q + CNT_W'(push) - CNT_W'(pop);

   // Flush first, then the push overwrites its own slot with the same-cycle kill.
   always_comb begin
      kill_nxt = kill_q;
      if (flush)
         kill_nxt = '1;
      if (push)
         kill_nxt[tail_q] = push_kill;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         kill_q  <= '0;
         count_q <= '0;
      end else begin
         if (push)
            tail_q <= tail_inc;
         if (pop)
            head_q <= head_inc;
         kill_q  <= kill_nxt;
         count_q <= count_nxt;
      end
   end

   assign count     = count_q;
   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_W'(DEPTH));
   assign head_kill = kill_q[head_q];

endmodule

// File: rtl/c7bifu_fcl_mo.sv
// IFU fetch control with multiple outstanding fetches: request issue under
// in-flight and IQ credit limits, stale-data kill on redirect, pf mux select.
module c7bifu_fcl_mo
   import c7bifu_pkg::*;
#(
   parameter int OUTSTANDING = 2,
   parameter int CNT_W       = 4
) (
   input  logic             clk,
   input  logic             resetn,
   c7bifu_fcl_mo_if.master  icu,
   input  logic             exu_ifu_except,
   input  logic             exu_ifu_branch,
   input  logic             exu_ifu_ertn,
   input  logic             exu_ifu_stall,
   input  logic [CNT_W-1:0] iq_free,
   output logic             pf_addr_sel_init,
   output logic             pf_addr_sel_old,
   output logic             pf_addr_sel_inc,
   output logic             pf_addr_sel_brn,
   output logic             pf_addr_sel_isr,
   output logic             pf_addr_sel_ert,
   output logic             pf_addr_en,
   output logic             icu_data_vld,
   output logic             stall,
   output logic             flush,
   output logic [CNT_W-1:0] inflight_cnt
);

   localparam int DEPTH = clamp_depth(OUTSTANDING);

   logic             req_q, init_q;
   logic             acc, issue, push, pop;
   logic             empty, full, head_kill;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   pf_sel_t          sel;

   assign flush = exu_ifu_except | exu_ifu_branch | exu_ifu_ertn;
   assign stall = exu_ifu_stall;

   assign acc  = req_q & icu.icu_ifu_ack_ic1;
   assign pop  = icu.icu_ifu_data_valid_ic2 & ~empty;
   // Issue limits keep the buffer from overflowing; the guard only backs that up.
   assign push = acc & (~full | pop);

   c7bifu_fcl_inflight #(
      .OUTSTANDING (DEPTH),
      .CNT_W       (CNT_W)
   ) u_inflight (
      .clk       (clk),
      .rst_n     (resetn),
      .push      (push),
      .push_kill (flush),
      .pop       (pop),
      .flush     (flush),
      .count     (cnt_q),
      .count_nxt (cnt_nxt),
      .empty     (empty),
      .full      (full),
      .head_kill (head_kill)
   );

   assign issue = init_q & (~req_q | acc)
                & (cnt_nxt < CNT_W'(DEPTH))
                & (cnt_nxt < iq_free);

   // A pending request is never withdrawn, not even by a redirect.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         req_q  <= 1'b0;
         init_q <= 1'b0;
      end else begin
         req_q  <= (req_q & ~acc) | issue;
         init_q <= 1'b1;
      end
   end

   always_comb begin
      sel = '0;
      if (!init_q)
         sel[SEL_INIT] = 1'b1;
      else if (exu_ifu_except)
         sel[SEL_ISR] = 1'b1;
      else if (exu_ifu_ertn)
         sel[SEL_ERT] = 1'b1;
      else if (exu_ifu_branch)
         sel[SEL_BRN] = 1'b1;
      else if (acc)
         sel[SEL_INC] = 1'b1;
      else
         sel[SEL_OLD] = 1'b1;
   end

   assign pf_addr_sel_init = sel[SEL_INIT];
   assign pf_addr_sel_old  = sel[SEL_OLD];
   assign pf_addr_sel_inc  = sel[SEL_INC];
   assign pf_addr_sel_brn  = sel[SEL_BRN];
   assign pf_addr_sel_isr  = sel[SEL_ISR];
   assign pf_addr_sel_ert  = sel[SEL_ERT];

   assign pf_addr_en   = ~init_q | flush | acc;
   assign icu_data_vld = icu.icu_ifu_data_valid_ic2 & ~empty & ~head_kill & ~flush;
   assign inflight_cnt = cnt_q;

   assign icu.ifu_icu_req_ic1 = req_q;

endmodule

// File: tb/tb_c7bifu_fcl_mo.sv
// Randomized scoreboard bench for c7bifu_fcl_mo against a queue-based fetch model.
module tb_c7bifu_fcl_mo;

   localparam int OUTSTANDING = 2;
   localparam int CNT_W       = 4;

   logic             clk = 1'b0;
   logic             resetn;
   logic             exu_ifu_except, exu_ifu_branch, exu_ifu_ertn, exu_ifu_stall;
   logic [CNT_W-1:0] iq_free;
   logic sel_init, sel_old, sel_inc, sel_brn, sel_isr, sel_ert;
   logic pf_addr_en, icu_data_vld, stall, flush;
   logic [CNT_W-1:0] inflight_cnt;

   always #5 clk = ~clk;

   c7bifu_fcl_mo_if icu_if ();

   c7bifu_fcl_mo #(.OUTSTANDING(OUTSTANDING), .CNT_W(CNT_W)) dut (
      .clk              (clk),
      .resetn           (resetn),
      .icu              (icu_if),
      .exu_ifu_except   (exu_ifu_except),
      .exu_ifu_branch   (exu_ifu_branch),
      .exu_ifu_ertn     (exu_ifu_ertn),
      .exu_ifu_stall    (exu_ifu_stall),
      .iq_free          (iq_free),
      .pf_addr_sel_init (sel_init),
      .pf_addr_sel_old  (sel_old),
      .pf_addr_sel_inc  (sel_inc),
      .pf_addr_sel_brn  (sel_brn),
      .pf_addr_sel_isr  (sel_isr),
      .pf_addr_sel_ert  (sel_ert),
      .pf_addr_en       (pf_addr_en),
      .icu_data_vld     (icu_data_vld),
      .stall            (stall),
      .flush            (flush),
      .inflight_cnt     (inflight_cnt)
   );

   // Expected per-cycle response; sel order is {init, old, inc, brn, isr, ert}.
   typedef struct {
      bit       req;
      int       cnt;
      bit [5:0] sel;
      bit       en;
      bit       vld;
      bit       flush;
      bit       stall;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Fetch model: one queue entry per acked fetch, holding "stale" for that fetch.
   bit   stale_q[$];
   bit   req_m;
   bit   init_m;
   int   cur_free;

   task automatic check(input string name, input int act, input int expv);
      n_chk++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("req",          int'(icu_if.ifu_icu_req_ic1), int'(e.req));
         check("inflight_cnt", int'(inflight_cnt), e.cnt);
         check("pf_sel",       int'({sel_init, sel_old, sel_inc, sel_brn, sel_isr, sel_ert}), int'(e.sel));
         check("pf_addr_en",   int'(pf_addr_en), int'(e.en));
         check("icu_data_vld", int'(icu_data_vld), int'(e.vld));
         check("flush",        int'(flush), int'(e.flush));
         check("stall",        int'(stall), int'(e.stall));
      end
   end

   always @(negedge clk) begin : protocol
      if (resetn && icu_if.icu_ifu_data_valid_ic2)
         assert (inflight_cnt != 0) else begin
            n_fail++;
            $display("FAIL data_valid_while_empty: inflight_cnt %0d at %0t", inflight_cnt, $time);
         end
   end

   task automatic model_cycle();
      exp_t e;
      bit   fl, acc, ack, dv;
      int   n;
      ack = icu_if.icu_ifu_ack_ic1;
      dv  = icu_if.icu_ifu_data_valid_ic2;
      fl  = exu_ifu_except | exu_ifu_branch | exu_ifu_ertn;
      acc = req_m && ack;
      e.req   = req_m;
      e.cnt   = stale_q.size();
      e.flush = fl;
      e.stall = exu_ifu_stall;
      e.vld   = dv && (stale_q.size() > 0) && !stale_q[0] && !fl;
      if (!init_m)             e.sel = 6'b100000;
      else if (exu_ifu_except) e.sel = 6'b000010;
      else if (exu_ifu_ertn)   e.sel = 6'b000001;
      else if (exu_ifu_branch) e.sel = 6'b000100;
      else if (acc)            e.sel = 6'b001000;
      else                     e.sel = 6'b010000;
      e.en = !init_m || fl || acc;
      exp_q.push_back(e);

      if (fl)
         foreach (stale_q[i]) stale_q[i] = 1'b1;
      if (dv && stale_q.size() > 0)
         void'(stale_q.pop_front());
      if (acc)
         stale_q.push_back(fl);
      n = stale_q.size();
      req_m  = (req_m && !acc) ||
               (init_m && (!req_m || acc) && n < OUTSTANDING && n < cur_free);
      init_m = 1'b1;
   endtask

   task automatic drive_idle();
      icu_if.icu_ifu_ack_ic1        = 1'b0;
      icu_if.icu_ifu_data_valid_ic2 = 1'b0;
      exu_ifu_except = 1'b0;
      exu_ifu_branch = 1'b0;
      exu_ifu_ertn   = 1'b0;
      exu_ifu_stall  = 1'b0;
   endtask

   task automatic run(input int cycles, input int ack_pct, input int dv_pct,
                      input int fl_pct, input int free_lo, input int free_hi);
      int r;
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         #1;
         if ($urandom_range(7) == 0)
            cur_free = $urandom_range(free_hi, free_lo);
         iq_free = CNT_W'(cur_free);
         icu_if.icu_ifu_ack_ic1        = ($urandom_range(99) < ack_pct);
         icu_if.icu_ifu_data_valid_ic2 = (stale_q.size() > 0) && ($urandom_range(99) < dv_pct);
         r = ($urandom_range(99) < fl_pct) ? $urandom_range(7, 1) : 0;
         exu_ifu_except = r[0];
         exu_ifu_branch = r[1];
         exu_ifu_ertn   = r[2];
         exu_ifu_stall  = ($urandom_range(3) == 0);
         model_cycle();
      end
   endtask

   task automatic reset_now(input int hold);
      @(posedge clk);
      #1;
      drive_idle();
      resetn = 1'b0;
      #1;
      check("rst_req",      int'(icu_if.ifu_icu_req_ic1), 0);
      check("rst_cnt",      int'(inflight_cnt), 0);
      check("rst_sel_init", int'(sel_init), 1);
      check("rst_en",       int'(pf_addr_en), 1);
      check("rst_vld",      int'(icu_data_vld), 0);
      stale_q.delete();
      req_m  = 1'b0;
      init_m = 1'b0;
      repeat (hold) @(posedge clk);
      #1;
      resetn = 1'b1;
      model_cycle();
   endtask

   initial begin
      resetn   = 1'b0;
      drive_idle();
      cur_free = 8;
      iq_free  = CNT_W'(cur_free);
      req_m    = 1'b0;
      init_m   = 1'b0;
      reset_now(3);

      run(60, 100, 70, 0, 8, 8);    // steady stream
      run(40, 80, 50, 0, 1, 1);     // one credit
      run(40, 80, 50, 0, 3, 3);     // two credits
      run(150, 70, 50, 15, 0, 8);   // redirects mixed in
      run(80, 100, 60, 40, 2, 8);   // frequent ack/flush coincidence
      reset_now(2);                 // reset with fetches in flight
      run(200, 60, 50, 10, 0, 8);

      @(posedge clk);
      #1;
      drive_idle();
      @(negedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/c7bifu_fcl_mo.md
Name: c7bifu_fcl_mo

Overview:
- Multi-outstanding fetch control for the IFU.
- Sits between the prefetch address register, the ICU request channel, the instruction queue (IQ) and the EXU redirect inputs.
- Allows up to OUTSTANDING acked-but-not-returned fetches, with IQ credit flow control.
- Tags each in-flight fetch with a kill bit so data made stale by a flush is dropped rather than forwarded.

Parameters:
OUTSTANDING, 2, max fetches acked with data not yet returned (1..8)
CNT_W, 4, width of credit/occupancy counts; must satisfy 2**CNT_W > OUTSTANDING

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
ifu_icu_req_ic1  out  1  fetch request; held until acked
icu_ifu_ack_ic1  in  1  ICU accepts request; ICU samples pf address this cycle
icu_ifu_data_valid_ic2  in  1  fetch data returns, strictly in ack order
exu_ifu_except  in  1  redirect to ISR
exu_ifu_branch  in  1  redirect to branch target
exu_ifu_ertn  in  1  redirect to exception return
exu_ifu_stall  in  1  downstream stall
iq_free  in  CNT_W  free IQ entries, registered by IQ
pf_addr_sel_init/old/inc/brn/isr/ert  out  1 each  one-hot pf address mux select
pf_addr_en  out  1  pf address register enable
icu_data_vld  out  1  returned data is live; write IQ
stall  out  1  = exu_ifu_stall
flush  out  1  = except | branch | ertn
inflight_cnt  out  CNT_W  current in-flight fetch count

Behaviour:
- Reset (async): req_q=0, inflight=0, all kill bits 0, init_q=0. Outputs: req=0, inflight_cnt=0, icu_data_vld=0, sel_init=1, pf_addr_en=1. init_q sets to 1 on the first clock after reset release.
- Accept: acc = req_q & ack. An ack with req_q=0 is ignored.
- Issue condition: issue = init_q & (~req_q | acc) & (inflight_nxt < OUTSTANDING) & (inflight_nxt < iq_free). inflight_nxt is the count after this cycle's push and pop.
- req_q_nxt = (req_q & ~acc) | issue. A pending request is never withdrawn, including on flush.
- In-flight buffer: circular, OUTSTANDING entries, each entry one kill bit.
  - Push on acc; kill = flush this cycle (same-cycle ack+flush fetched the old address, so it is stale).
  - Pop on data_valid when not empty.
  - On flush, set kill on every valid entry. A push in the same cycle is also killed.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- icu_data_vld = data_valid & ~empty & ~head_kill & ~flush. A flush in the same cycle as data return drops the data.
- data_valid while empty: no pop, no output. This is a protocol error; the bench asserts on it.
- Pf address select, priority init > isr > ert > brn > inc > old, exactly one select high:
  - init = ~init_q.
  - isr/ert/brn = the corresponding EXU input.
  - inc = acc & ~flush.
  - old otherwise.
- pf_addr_en = ~init_q | flush | acc.
- Flush while a request is pending without ack: the address register loads the target. The later ack samples the new address, and that fetch is live (kill=0).
- inflight_cnt saturates by construction; it never exceeds OUTSTANDING.
- Reset mid-operation clears everything. In-flight data returning after reset finds the buffer empty and is dropped.

Decomposition:
- Shared package c7bifu_pkg: the pf select index constants (SEL_INIT..SEL_ERT) and the OUTSTANDING upper bound.
- One sub-module, c7bifu_fcl_inflight: the kill-bit circular buffer with push, pop, flush-kill-all, count, empty and full. The top level holds the request, init and select logic.

Test Plan:
- Steady stream, OUTSTANDING=2, iq_free=8, ack 1 cycle after req, data 2 cycles after ack -> inflight_cnt reaches 2 and holds; req drops while count=2; one icu_data_vld per ack; sel_inc exactly once per ack.
- Credit limit: iq_free=1 -> at most one fetch in flight; req stays low until data returns; raising iq_free=3 permits 2 in flight.
- Flush with 2 in flight (branch=1 one cycle) -> both returns have icu_data_vld=0; sel_brn=1, pf_addr_en=1 that cycle; the next acked fetch returns with icu_data_vld=1.
- Ack and except same cycle -> entry pushed killed; its data is dropped; sel_isr=1 (not inc); a new req issues next cycle.
- except and branch together -> only sel_isr=1. Data_valid and flush same cycle -> icu_data_vld=0 and the head is popped.
- Reset asserted with 2 in flight and req high -> req=0, inflight_cnt=0, sel_init=1 immediately; after release, sel_init stays 1 for one clock, then req rises.
